// File: rtl/uart_loader_pkg.sv
// Shared types and helpers for the UART instruction loader.
// RX and loader state encodings plus idle-counter sizing.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic {
    LD_LOAD,
    LD_DONE
  } ld_state_e;

  function automatic int idle_cnt_w(
    input int idle_bits,
    input int clk_per_bit
  );
    return $clog2(idle_bits * clk_per_bit + 1);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-FF input synchroniser.
// Emits one-cycle byte_valid / frame_err pulses at the stop bit.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       line_idle_o,
  output logic       fall_o
);

  localparam int CW = $clog2(CLK_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);

  logic            s1_q;
  logic            s2_q;
  logic            prev_q;
  rx_state_e       st_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      sh_q;
  logic [7:0]      byte_q;
  logic            vld_q;
  logic            ferr_q;

  assign fall_o       = prev_q & ~s2_q;
  assign line_idle_o  = (st_q == RX_IDLE);
  assign byte_o       = byte_q;
  assign byte_valid_o = vld_q;
  assign frame_err_o  = ferr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= RX_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      byte_q <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      unique case (st_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (fall_o) st_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            bit_q <= '0;
            st_q  <= s2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q <= '0;
            sh_q  <= {s2_q, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) st_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL) begin
            cnt_q <= '0;
            st_q  <= RX_IDLE;
            if (s2_q) begin
              vld_q  <= 1'b1;
              byte_q <= sh_q;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_instr_loader.sv
// UART-fed instruction RAM: packs bytes MSB-first into words,
// ends the load on idle timeout or full RAM, registered read port.
module uart_instr_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int INSTR_W     = 16,
  parameter int ADDR_W      = 8,
  parameter int IDLE_BITS   = 32
) (
  input  logic               i_clk_uart,
  input  logic               i_rst_n,
  input  logic               i_rx,
  input  logic               i_clear,
  input  logic [ADDR_W-1:0]  i_addr_read,
  output logic [INSTR_W-1:0] o_instr_read,
  output logic               o_instr_transmit_done,
  output logic [ADDR_W-1:0]  o_max_addr,
  output logic [ADDR_W:0]    o_word_count,
  output logic               o_frame_err,
  output logic               o_partial_err,
  output logic               o_overflow
);

  localparam int NB    = INSTR_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IW    = idle_cnt_w(IDLE_BITS, CLK_PER_BIT);
  localparam logic [IW-1:0]   TERM  = IW'(IDLE_BITS * CLK_PER_BIT);
  localparam logic [ADDR_W:0] FULLC = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      LAST  = 4'(NB - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;
  logic       line_idle;
  logic       rx_fall;

  uart_rx_byte #(
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_rx (
    .clk_i        (i_clk_uart),
    .rst_ni       (i_rst_n),
    .rx_i         (i_rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr),
    .line_idle_o  (line_idle),
    .fall_o       (rx_fall)
  );

  ld_state_e          ld_q;
  logic               done_q;
  logic [ADDR_W-1:0]  wptr_q;
  logic [ADDR_W:0]    cnt_q;
  logic [ADDR_W-1:0]  max_q;
  logic [3:0]         bcnt_q;
  logic [INSTR_W-1:0] word_q;
  logic [IW-1:0]      idle_q;
  logic               ferr_q;
  logic               perr_q;
  logic               ovf_q;
  logic [INSTR_W-1:0] rd_q;
  logic [INSTR_W-1:0] mem_q [DEPTH];

  logic [INSTR_W-1:0] word_nx;
  logic               armed;
  logic               full;
  logic               timeout;
  logic               we;

  assign word_nx = (word_q << 8) | INSTR_W'(rx_byte);
  assign armed   = (cnt_q != '0) || (bcnt_q != '0);
  assign full    = (cnt_q == FULLC);
  assign timeout = (ld_q == LD_LOAD) && armed && line_idle
                   && !rx_fall && (idle_q == TERM);
  assign we      = rx_valid && (ld_q == LD_LOAD) && (bcnt_q == LAST)
                   && !full && !timeout && !i_clear;

  always_ff @(posedge i_clk_uart or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ld_q   <= LD_LOAD;
      done_q <= 1'b0;
      wptr_q <= '0;
      cnt_q  <= '0;
      max_q  <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      idle_q <= '0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (i_clear) begin
      ld_q   <= LD_LOAD;
      done_q <= 1'b0;
      wptr_q <= '0;
      cnt_q  <= '0;
      max_q  <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      idle_q <= '0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (rx_ferr) ferr_q <= 1'b1;
      // Counter only advances on a quiet line during an armed load
      if (rx_fall || !line_idle || !armed || ld_q != LD_LOAD)
        idle_q <= '0;
      else if (idle_q != TERM)
        idle_q <= idle_q + IW'(1);
      unique case (ld_q)
        LD_LOAD: begin
          if (full) begin
            ld_q   <= LD_DONE;
            done_q <= 1'b1;
          end else if (timeout) begin
            ld_q   <= LD_DONE;
            done_q <= 1'b1;
            if (bcnt_q != '0) begin
              perr_q <= 1'b1;
              bcnt_q <= '0;
            end
          end else if (rx_valid) begin
            word_q <= word_nx;
            if (bcnt_q == LAST) begin
              bcnt_q <= '0;
              wptr_q <= wptr_q + ADDR_W'(1);
              cnt_q  <= cnt_q + (ADDR_W + 1)'(1);
              max_q  <= wptr_q;
            end else begin
              bcnt_q <= bcnt_q + 4'd1;
            end
          end
        end
        LD_DONE: begin
          if (rx_valid) ovf_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk_uart) begin
    if (we) mem_q[wptr_q] <= word_nx;
  end

  always_ff @(posedge i_clk_uart or negedge i_rst_n) begin
    if (!i_rst_n) rd_q <= '0;
    else          rd_q <= mem_q[i_addr_read];
  end

  assign o_instr_read          = rd_q;
  assign o_instr_transmit_done = done_q;
  assign o_max_addr            = max_q;
  assign o_word_count          = cnt_q;
  assign o_frame_err           = ferr_q;
  assign o_partial_err         = perr_q;
  assign o_overflow            = ovf_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader: one large-RAM instance
// and one ADDR_W=2 instance sharing clock and reset.
module tb_uart_instr_loader;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        rx2 = 1'b1;
  logic        clear = 1'b0;
  logic [7:0]  addr = '0;
  logic [1:0]  addr2 = '0;

  logic [15:0] instr;
  logic        done;
  logic [7:0]  max_a;
  logic [8:0]  wc;
  logic        ferr, perr, ovf;

  logic [15:0] instr2;
  logic        done2;
  logic [1:0]  max2;
  logic [2:0]  wc2;
  logic        ferr2, perr2, ovf2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_instr_loader #(
    .CLK_PER_BIT (CPB), .INSTR_W (16), .ADDR_W (8), .IDLE_BITS (32)
  ) dut (
    .i_clk_uart (clk), .i_rst_n (rst_n), .i_rx (rx), .i_clear (clear),
    .i_addr_read (addr), .o_instr_read (instr),
    .o_instr_transmit_done (done), .o_max_addr (max_a),
    .o_word_count (wc), .o_frame_err (ferr),
    .o_partial_err (perr), .o_overflow (ovf)
  );

  uart_instr_loader #(
    .CLK_PER_BIT (CPB), .INSTR_W (16), .ADDR_W (2), .IDLE_BITS (32)
  ) dut2 (
    .i_clk_uart (clk), .i_rst_n (rst_n), .i_rx (rx2), .i_clear (1'b0),
    .i_addr_read (addr2), .o_instr_read (instr2),
    .o_instr_transmit_done (done2), .o_max_addr (max2),
    .o_word_count (wc2), .o_frame_err (ferr2),
    .o_partial_err (perr2), .o_overflow (ovf2)
  );

  task automatic drive(input int which, input logic v);
    if (which == 0) rx = v;
    else rx2 = v;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sb,
                           input int which);
    logic [9:0] fr;
    fr = {sb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(which, fr[i]);
      repeat (CPB) @(negedge clk);
    end
    drive(which, 1'b1);
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic wait_done(input int which, input string nm);
    int n;
    n = 0;
    while (((which == 0) ? done : done2) !== 1'b1 && n < 60 * CPB) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (((which == 0) ? done : done2) !== 1'b1) begin
      bad++;
      $display("FAIL %s: done not seen within %0d cycles, want 1", nm, n);
    end
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a;
    @(posedge clk);
    #1 d = instr;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({instr, done, max_a, wc, ferr, perr, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {instr, done, max_a, wc, ferr, perr, ovf});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_default_load();
    logic [7:0]  bytes [4];
    logic [15:0] d;
    bytes = '{8'hA5, 8'h5A, 8'h3C, 8'h2B};
    foreach (bytes[i]) send_byte(bytes[i], 1'b1, 0);
    for (int i = 0; i < 14; i++) send_byte(8'h10, 1'b1, 0);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL dflt_early_done: got %b want 0", done);
    end
    wait_done(0, "dflt_done");
    total++;
    if (wc !== 9'd9) begin
      bad++;
      $display("FAIL dflt_count: got %0d want 9", wc);
    end
    total++;
    if (max_a !== 8'd8) begin
      bad++;
      $display("FAIL dflt_max_addr: got %0d want 8", max_a);
    end
    rd(8'd0, d);
    total++;
    if (d !== 16'hA55A) begin
      bad++;
      $display("FAIL dflt_word0: got %h want a55a", d);
    end
    rd(8'd1, d);
    total++;
    if (d !== 16'h3C2B) begin
      bad++;
      $display("FAIL dflt_word1: got %h want 3c2b", d);
    end
    rd(8'd2, d);
    total++;
    if (d !== 16'h1010) begin
      bad++;
      $display("FAIL dflt_word2: got %h want 1010", d);
    end
    @(negedge clk);
    addr = 8'd0;
    #1;
    total++;
    if (instr !== 16'h1010) begin
      bad++;
      $display("FAIL rd_latency_hold: got %h want 1010", instr);
    end
    @(posedge clk);
    #1;
    total++;
    if (instr !== 16'hA55A) begin
      bad++;
      $display("FAIL rd_latency_one: got %h want a55a", instr);
    end
    total++;
    if ({ferr, perr, ovf} !== 3'b000) begin
      bad++;
      $display("FAIL dflt_flags: got %b want 000", {ferr, perr, ovf});
    end
  endtask

  task automatic test_frame_err();
    logic [15:0] d;
    pulse_clear();
    total++;
    if ({done, wc, max_a} !== '0) begin
      bad++;
      $display("FAIL clear_after_load: got %h want 0", {done, wc, max_a});
    end
    send_byte(8'hA5, 1'b0, 0);
    send_byte(8'h5A, 1'b1, 0);
    send_byte(8'h3C, 1'b1, 0);
    wait_done(0, "ferr_done");
    total++;
    if (ferr !== 1'b1) begin
      bad++;
      $display("FAIL ferr_flag: got %b want 1", ferr);
    end
    total++;
    if (wc !== 9'd1) begin
      bad++;
      $display("FAIL ferr_count: got %0d want 1", wc);
    end
    rd(8'd0, d);
    total++;
    if (d !== 16'h5A3C) begin
      bad++;
      $display("FAIL ferr_word0: got %h want 5a3c", d);
    end
  endtask

  task automatic test_partial();
    logic [15:0] d;
    pulse_clear();
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    send_byte(8'h33, 1'b1, 0);
    wait_done(0, "part_done");
    total++;
    if (perr !== 1'b1) begin
      bad++;
      $display("FAIL part_flag: got %b want 1", perr);
    end
    total++;
    if (wc !== 9'd1 || ferr !== 1'b0) begin
      bad++;
      $display("FAIL part_count: got wc=%0d ferr=%b want 1/0", wc, ferr);
    end
    rd(8'd0, d);
    total++;
    if (d !== 16'h1122) begin
      bad++;
      $display("FAIL part_word0: got %h want 1122", d);
    end
  endtask

  task automatic test_glitch_clear();
    logic [15:0] d;
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    total++;
    if (wc !== 9'd1 || ferr !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL glitch: got wc=%0d ferr=%b ovf=%b want 1/0/0",
               wc, ferr, ovf);
    end
    pulse_clear();
    total++;
    if ({done, wc, max_a, ferr, perr, ovf} !== '0) begin
      bad++;
      $display("FAIL clear_state: got %h want 0",
               {done, wc, max_a, ferr, perr, ovf});
    end
    send_byte(8'h77, 1'b1, 0);
    send_byte(8'h88, 1'b1, 0);
    wait_done(0, "reload_done");
    rd(8'd0, d);
    total++;
    if (d !== 16'h7788 || wc !== 9'd1 || max_a !== 8'd0) begin
      bad++;
      $display("FAIL reload: got %h wc=%0d max=%0d want 7788/1/0",
               d, wc, max_a);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({instr, done, max_a, wc, ferr, perr, ovf} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got %h want 0",
               {instr, done, max_a, wc, ferr, perr, ovf});
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h5A, 1'b1, 0);
    wait_done(0, "rst_mid_done");
    rd(8'd0, d);
    total++;
    if (d !== 16'hA55A || wc !== 9'd1 || ferr !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_word0: got %h wc=%0d ferr=%b want a55a/1/0",
               d, wc, ferr);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 7; i++) send_byte(8'(i), 1'b1, 1);
    total++;
    if (done2 !== 1'b0 || wc2 !== 3'd3) begin
      bad++;
      $display("FAIL ovf_pre_full: got done=%b wc=%0d want 0/3", done2, wc2);
    end
    send_byte(8'h08, 1'b1, 1);
    total++;
    if (done2 !== 1'b1) begin
      bad++;
      $display("FAIL ovf_full_done: got %b want 1", done2);
    end
    total++;
    if (wc2 !== 3'd4 || max2 !== 2'd3) begin
      bad++;
      $display("FAIL ovf_count: got wc=%0d max=%0d want 4/3", wc2, max2);
    end
    total++;
    if (ovf2 !== 1'b0) begin
      bad++;
      $display("FAIL ovf_early: got %b want 0", ovf2);
    end
    send_byte(8'h09, 1'b1, 1);
    send_byte(8'h0A, 1'b1, 1);
    total++;
    if (ovf2 !== 1'b1 || wc2 !== 3'd4) begin
      bad++;
      $display("FAIL ovf_flag: got ovf=%b wc=%0d want 1/4", ovf2, wc2);
    end
    @(negedge clk);
    addr2 = 2'd0;
    @(posedge clk);
    #1;
    total++;
    if (instr2 !== 16'h0102) begin
      bad++;
      $display("FAIL ovf_word0: got %h want 0102", instr2);
    end
    @(negedge clk);
    addr2 = 2'd3;
    @(posedge clk);
    #1;
    total++;
    if (instr2 !== 16'h0708) begin
      bad++;
      $display("FAIL ovf_word3: got %h want 0708", instr2);
    end
  endtask

  initial begin
    test_reset();
    test_default_load();
    test_frame_err();
    test_partial();
    test_glitch_clear();
    test_reset_mid();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_instr_loader.md
# uart_instr_loader

Parametrised successor to the UART-loaded instruction ROM. Receives 8N1 UART bytes and packs them MSB-first into INSTR_W-bit instruction words, written sequentially into an internal RAM from address 0. Declares the load complete on an idle-line timeout or when the RAM is full. Exposes a registered read port for the CPU fetch path, plus load status and error flags.

## Interface
- CLK_PER_BIT, default 868: clocks per UART bit (100 MHz / 115200).
- INSTR_W, default 16: instruction width; must be a multiple of 8, from 8 to 64.
- ADDR_W, default 8: RAM address width; depth = 2**ADDR_W words.
- IDLE_BITS, default 32: idle-line bit times after the last stop bit that end the load.
- i_clk_uart  in  1  single clock for the whole block.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx  in  1  UART serial input, idle high, asynchronous to i_clk_uart.
- i_clear  in  1  one-cycle pulse: re-arm the loader (pointer, count, flags to reset values); RAM contents are kept.
- i_addr_read  in  ADDR_W  read address.
- o_instr_read  out  INSTR_W  read data, registered.
- o_instr_transmit_done  out  1  load complete, sticky until reset or i_clear.
- o_max_addr  out  ADDR_W  address of the last word written; 0 if none.
- o_word_count  out  ADDR_W+1  number of words written.
- o_frame_err  out  1  sticky: a byte was received with stop bit = 0.
- o_partial_err  out  1  sticky: the timeout fired with an incomplete word pending.
- o_overflow  out  1  sticky: a byte arrived after the RAM was full.

## Operation
- i_rx passes through a 2-FF synchroniser; all decoding uses the synchronised value.
- RX FSM states:
  - IDLE: a falling edge goes to START.
  - START: at CLK_PER_BIT/2, re-sample. Low goes to DATA; high (glitch) returns to IDLE.
  - DATA: sample every CLK_PER_BIT, LSB first, 8 bits, then go to STOP.
  - STOP: sample once. High: byte_valid pulses for one cycle. Low: byte dropped, o_frame_err set. Either way, return to IDLE.
- Word packer: a byte counter runs 0..INSTR_W/8-1. The first byte received fills the MSBs. On the last byte, the word is written at the write pointer, the pointer increments, and o_word_count increments.
- Loader FSM states:
  - LOAD: on timeout or full, go to DONE.
  - DONE: ignore all further bytes; raise o_overflow on any byte.
- Timeout: the idle counter clears on every falling edge of i_rx and runs while the RX FSM is in IDLE. It is armed only when o_word_count>0 or a byte is pending. It fires at IDLE_BITS*CLK_PER_BIT cycles. If a partial word is pending, that word is discarded and o_partial_err is set.
- Full: when o_word_count reaches 2**ADDR_W, go to DONE immediately without waiting for the timeout.
- Read port: o_instr_read <= mem[i_addr_read] every cycle, independent of load state. Reading during a load returns the old contents of unwritten addresses.

## Timing
- Reset values: o_instr_read=0, o_instr_transmit_done=0, o_max_addr=0, o_word_count=0, all error flags=0, FSMs in IDLE/LOAD, packer counter=0. The RAM is not cleared.
- byte_valid occurs 2 cycles (synchroniser) after the mid-stop-bit point.
- RAM write occurs 1 cycle after byte_valid. o_max_addr and o_word_count update in that same cycle.
- o_instr_transmit_done rises 1 cycle after the timeout count is reached, or 1 cycle after the write that fills the RAM.
- Read latency is 1 cycle, from i_addr_read to o_instr_read.
- Simultaneous events:
  - i_clear has priority over a same-cycle write; that write is dropped.
  - A falling edge in the same cycle as the timeout terminal count clears the counter; no timeout fires.
- Reset mid-byte: the frame in progress is abandoned. The RX FSM resynchronises on the next falling edge after reset release.

## Structure
- Package uart_loader_pkg holds:
  - the RX state enum (IDLE/START/DATA/STOP);
  - the loader state enum (LOAD/DONE);
  - the function computing the idle-counter width, $clog2(IDLE_BITS*CLK_PER_BIT+1).
- Sub-module uart_rx_byte contains the synchroniser and RX FSM; outputs are byte, byte_valid, frame_err_pulse, and line_idle.
- The top contains the packer, loader FSM, timeout counter and RAM. The RAM is inferred as simple dual-port BRAM.

## Test plan
- Defaults: send bytes A5, 5A, 3C, 2B, then 10 fourteen times, with 3 idle bits between bytes. Then idle more than 32 bit times. Required: o_word_count=9, o_max_addr=8, o_instr_transmit_done=1. Reading addresses 0/1/2 gives A55A/3C2B/1010, each 1 cycle after the address is applied.
- Send A5 with stop bit forced to 0, then 5A, 3C. Required: o_frame_err=1, and word 0=5A3C.
- Send 3 bytes, then idle. Required: o_word_count=1, o_partial_err=1, done=1.
- ADDR_W=2: send 10 bytes. Required: done after the 8th byte, o_word_count=4, o_max_addr=3, o_overflow=1, and mem[0] not overwritten.
- Put a 2-cycle low glitch on i_rx. Required: no byte and no error. Then pulse i_clear. Required: count/flags reset to 0 and the next load starts again at address 0.
- Assert i_rst_n low mid-DATA. Required: all outputs at reset values. After release, a clean A5, 5A loads word 0=A55A.
